// File: rtl/rr_dequeue_ctrl.sv
// +----------------------------------------------------------------------------+
// | rr_dequeue_ctrl: pops the arbiter-granted queue into a valid/ready output  |
// | register. Optional RR_DEQUEUE_STATS_EN adds per-queue pop counters. Rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_dequeue_ctrl #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int BUF_WIDTH      = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0]   selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] buf_data,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                data_valid,
  input  logic                                data_ready,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]   queue_id,
  output logic                                err_sel
`ifdef RR_DEQUEUE_STATS_EN
  ,
  output logic [QUEUE_QUANTITY*(BUF_WIDTH+8)-1:0] pop_count
`endif
);

  localparam int SEL_W = $clog2(QUEUE_QUANTITY);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [DATA_BITS-1:0] data_q;
  logic [SEL_W-1:0]     qid_q;
  logic                 err_q, err_d;

  logic                 sel_empty;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_oor;
  logic                 acc;

  // Out-of-range selectors fall through with sel_empty=1 so they never pop.
  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (selector == SEL_W'(i)) begin
        sel_empty = buf_empty[i];
        sel_data  = buf_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  generate
    if ((1 << SEL_W) > QUEUE_QUANTITY) begin : g_sel_range
      assign sel_oor = (32'(selector) >= 32'(QUEUE_QUANTITY));
    end else begin : g_sel_pow2
      assign sel_oor = 1'b0;
    end
  endgenerate

  assign acc = rst & enb & selector_enb & ~sel_oor & ~sel_empty
             & ((state_q == ST_EMPTY) | data_ready);

  always_comb begin
    pop = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      pop[i] = acc & (selector == SEL_W'(i));
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (enb) begin
      case (state_q)
        ST_EMPTY: if (acc) state_d = ST_FULL;
        ST_FULL: begin
          if (acc)             state_d = ST_FULL;
          else if (data_ready) state_d = ST_EMPTY;
        end
        default:               state_d = ST_EMPTY;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    data_valid = (state_q == ST_FULL);
  end

  assign err_d = enb & selector_enb & (sel_oor | sel_empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      qid_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (acc) begin
        data_q <= sel_data;
        qid_q  <= selector;
      end
    end
  end

  assign data_out = data_q;
  assign queue_id = qid_q;
  assign err_sel  = err_q;

`ifdef RR_DEQUEUE_STATS_EN
  localparam int CNT_W = BUF_WIDTH + 8;

  generate
    for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_stats
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else if (pop[g] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign pop_count[g*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate
`endif

endmodule

`default_nettype wire
